// File: rtl/sms4_host_driver.sv
// Host-side job driver for an SMS4 block-cipher core.
// Accepts one host job at a time, reloads the key if needed, issues the data
// command, waits for the result under a timeout and returns it to the host.
module sms4_host_driver #(
    parameter int unsigned DWIDTH  = 128,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    // host request
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DWIDTH-1:0] req_key,
    input  logic [DWIDTH-1:0] req_data,
    input  logic              req_enc,
    input  logic              req_newkey,
    // host response
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_data,
    output logic              rsp_err,
    // core command side
    output logic [DWIDTH-1:0] kin,
    output logic [1:0]        kvld,
    output logic [DWIDTH-1:0] din,
    output logic              load,
    output logic              start,
    output logic              enc,
    // core status side
    input  logic [DWIDTH-1:0] dout,
    input  logic              busy,
    input  logic              ready,
    input  logic              kstr,
    input  logic [DWIDTH-1:0] kout
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        KEY,
        KWAIT,
        DATA,
        DWAIT,
        RESP
    } state_t;

    state_t            state;
    logic [CW-1:0]     wait_cnt;
    logic              key_loaded;
    logic [DWIDTH-1:0] data_q;
    logic              enc_q;

    // The core's key readback is not needed by this driver.
    logic kout_unused;
    assign kout_unused = ^kout;

    // Job sequencing FSM; every output is registered and strobes last one cycle.
    // kvld is raised on the accepting edge so it coincides with the KEY state;
    // load/start are raised on the edge that samples busy=0 in DATA.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            key_loaded <= 1'b0;
            data_q     <= '0;
            enc_q      <= 1'b0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            kin        <= '0;
            kvld       <= 2'b00;
            din        <= '0;
            load       <= 1'b0;
            start      <= 1'b0;
            enc        <= 1'b0;
        end else begin
            kvld  <= 2'b00;
            load  <= 1'b0;
            start <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_ready && req_valid) begin
                        req_ready <= 1'b0;
                        data_q    <= req_data;
                        enc_q     <= req_enc;
                        if (req_newkey || !key_loaded) begin
                            kvld  <= 2'b11;
                            kin   <= req_key;
                            state <= KEY;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                KEY: begin
                    wait_cnt <= '0;
                    state    <= KWAIT;
                end
                KWAIT: begin
                    // The awaited event has priority over the timeout.
                    if (kstr) begin
                        key_loaded <= 1'b1;
                        state      <= DATA;
                    end else if (wait_cnt == CNT_LAST) begin
                        key_loaded <= 1'b0;
                        rsp_err    <= 1'b1;
                        rsp_data   <= '0;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (!busy) begin
                        load     <= 1'b1;
                        start    <= 1'b1;
                        din      <= data_q;
                        enc      <= enc_q;
                        wait_cnt <= '0;
                        state    <= DWAIT;
                    end
                end
                DWAIT: begin
                    if (ready) begin
                        rsp_data  <= dout;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (wait_cnt == CNT_LAST) begin
                        key_loaded <= 1'b0;
                        rsp_err    <= 1'b1;
                        rsp_data   <= '0;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
